// File: rtl/rv_alu_pkg.sv
// ---------------------------------------------------------------------------
// rv_alu_pkg
// Shared types and constants for the RV32I ALU decoder:
//   - alu_op_e      : 4-bit ALU operation code driven to the execute stage
//   - opcode/funct3/funct7 encodings used by the decoder
//   - dec_ctrl_t    : decoded control bundle (everything except the
//                     immediate, whose width follows the decoder parameter N)
//   - skid_state_e  : occupancy states of the 2-entry output skid buffer
// ---------------------------------------------------------------------------
package rv_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SRA  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 values with no branch instruction assigned
    localparam logic [2:0] F3_BR_RSV0 = 3'b010;
    localparam logic [2:0] F3_BR_RSV1 = 3'b011;

    // funct7: base encoding and the alternate (sub / sra) encoding
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e    alu_op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       src1_pc;
        logic       src2_imm;
        logic       rd_we;
        logic       is_branch;
        logic       illegal;
        logic [2:0] br_cond;
    } dec_ctrl_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/rv_dec_skid.sv
// ---------------------------------------------------------------------------
// rv_dec_skid
// Two-entry skid buffer with fully registered outputs. An accepted word is
// visible on out_data_o the cycle after acceptance; with out_ready_i high it
// sustains one word per cycle. in_ready_o is a register, low only when both
// entries are occupied.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid_i/o_ready: upstream handshake, in_data_i [W-1:0]
//   out_valid_o       : head entry present, out_data_o [W-1:0]
//   out_ready_i       : downstream accepts the head entry
// ---------------------------------------------------------------------------
module rv_dec_skid
    import rv_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    skid_state_e  state_q;
    logic [W-1:0] head_q;      // entry presented downstream
    logic [W-1:0] tail_q;      // overflow entry, valid only in SKID_TWO
    logic         in_ready_q;
    logic         out_valid_q;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid_i & in_ready_q;
    assign out_xfer = out_valid_q & out_ready_i;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples values from before the edge, independent of statement order.
    // NOTE: the payload registers are reset as well, because the decoded
    // outputs must read as zero after reset, not just be marked invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SKID_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_xfer) begin
                        head_q      <= in_data_i;
                        out_valid_q <= 1'b1;
                        state_q     <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (in_xfer && out_xfer) begin
                        // Head leaves while the new word replaces it.
                        head_q <= in_data_i;
                    end else if (in_xfer) begin
                        tail_q     <= in_data_i;
                        in_ready_q <= 1'b0;
                        state_q    <= SKID_TWO;
                    end else if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_xfer) begin
                        head_q     <= tail_q;
                        in_ready_q <= 1'b1;
                        state_q    <= SKID_ONE;
                    end
                end
                default: begin
                    state_q     <= SKID_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = head_q;

endmodule

// File: rtl/rv_alu_decode.sv
// ---------------------------------------------------------------------------
// rv_alu_decode
// RV32I ALU-instruction decoder: combinational decode of OP, OP-IMM, LUI and
// AUIPC (plus BRANCH when RV_DEC_BRANCH_EN is defined) into an ALU control
// bundle, registered through a 2-entry skid buffer (rv_dec_skid).
// Configuration macro: RV_DEC_BRANCH_EN -- enables BRANCH decode; when
// undefined BRANCH is illegal and br_cond is constant 0.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : instruction handshake, instr [31:0]
//   out_valid/out_ready   : decoded-bundle handshake
//   alu_op [3:0]          : ALU operation (rv_alu_pkg::alu_op_e encoding)
//   rd, rs1, rs2 [4:0]    : register indices
//   imm [N-1:0]           : sign-extended immediate
//   src1_pc, src2_imm     : operand selects
//   rd_we, is_branch      : write-back enable, branch marker
//   illegal               : instruction not decodable here
//   br_cond [2:0]         : branch funct3 for the downstream flag compare
// ---------------------------------------------------------------------------
module rv_alu_decode
    import rv_alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   alu_op,
    output logic [4:0]   rd,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic [N-1:0] imm,
    output logic         src1_pc,
    output logic         src2_imm,
    output logic         rd_we,
    output logic         is_branch,
    output logic         illegal,
    output logic [2:0]   br_cond
);

    localparam int CTRL_W = $bits(dec_ctrl_t);
    localparam int PAY_W  = CTRL_W + N;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    dec_ctrl_t   ctrl_d;
    logic [31:0] imm32_d;
    logic [N-1:0] imm_d;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // NOTE: every field gets a default before the case so no path through
    // this block leaves a signal unassigned (which would infer a latch).
    always_comb begin
        ctrl_d        = '0;
        ctrl_d.alu_op = ALU_ADD;
        ctrl_d.rd     = instr[11:7];
        ctrl_d.rs1    = instr[19:15];
        ctrl_d.rs2    = instr[24:20];
        imm32_d       = '0;

        case (opcode)
            OPC_OP: begin
                ctrl_d.rd_we   = 1'b1;
                // Only add/sub and srl/sra accept the alternate funct7.
                ctrl_d.illegal = (funct7 != F7_ZERO);
                case (funct3)
                    F3_ADD_SUB: begin
                        ctrl_d.alu_op  = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                        ctrl_d.illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                    end
                    F3_SR: begin
                        ctrl_d.alu_op  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        ctrl_d.illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                    end
                    F3_SLL:  ctrl_d.alu_op = ALU_SLL;
                    F3_SLT:  ctrl_d.alu_op = ALU_SLT;
                    F3_SLTU: ctrl_d.alu_op = ALU_SLTU;
                    F3_XOR:  ctrl_d.alu_op = ALU_XOR;
                    F3_OR:   ctrl_d.alu_op = ALU_OR;
                    default: ctrl_d.alu_op = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                ctrl_d.rd_we    = 1'b1;
                ctrl_d.src2_imm = 1'b1;
                imm32_d         = {{20{instr[31]}}, instr[31:20]};
                case (funct3)
                    F3_SLL: begin
                        ctrl_d.alu_op  = ALU_SLL;
                        imm32_d        = {27'd0, instr[24:20]};
                        ctrl_d.illegal = (funct7 != F7_ZERO);
                    end
                    F3_SR: begin
                        ctrl_d.alu_op  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        imm32_d        = {27'd0, instr[24:20]};
                        ctrl_d.illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                    end
                    // There is no subi: funct3 000 is always add.
                    F3_ADD_SUB: ctrl_d.alu_op = ALU_ADD;
                    F3_SLT:     ctrl_d.alu_op = ALU_SLT;
                    F3_SLTU:    ctrl_d.alu_op = ALU_SLTU;
                    F3_XOR:     ctrl_d.alu_op = ALU_XOR;
                    F3_OR:      ctrl_d.alu_op = ALU_OR;
                    default:    ctrl_d.alu_op = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                ctrl_d.rd_we    = 1'b1;
                ctrl_d.src2_imm = 1'b1;
                ctrl_d.rs1      = 5'd0;   // x0 + imm
                imm32_d         = {instr[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                ctrl_d.rd_we    = 1'b1;
                ctrl_d.src1_pc  = 1'b1;
                ctrl_d.src2_imm = 1'b1;
                imm32_d         = {instr[31:12], 12'd0};
            end
`ifdef RV_DEC_BRANCH_EN
            OPC_BRANCH: begin
                ctrl_d.alu_op    = ALU_SUB;
                ctrl_d.is_branch = 1'b1;
                ctrl_d.br_cond   = funct3;
                imm32_d          = {{19{instr[31]}}, instr[31], instr[7],
                                    instr[30:25], instr[11:8], 1'b0};
                ctrl_d.illegal   = (funct3 == F3_BR_RSV0) || (funct3 == F3_BR_RSV1);
            end
`endif
            default: begin
                ctrl_d.illegal = 1'b1;
            end
        endcase

        // An illegal word must never write back or redirect control flow.
        if (ctrl_d.illegal) begin
            ctrl_d.rd_we     = 1'b0;
            ctrl_d.is_branch = 1'b0;
        end
    end

    // Sign-extend (or truncate) the 32-bit immediate to the datapath width.
    generate
        if (N == 32) begin : g_imm_eq
            assign imm_d = imm32_d;
        end else if (N > 32) begin : g_imm_ext
            assign imm_d = {{(N-32){imm32_d[31]}}, imm32_d};
        end else begin : g_imm_trunc
            assign imm_d = imm32_d[N-1:0];
        end
    endgenerate

    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;
    dec_ctrl_t        ctrl_q;

    assign pay_in = {ctrl_d, imm_d};

    rv_dec_skid #(
        .W (PAY_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (pay_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (pay_out)
    );

    assign ctrl_q    = dec_ctrl_t'(pay_out[PAY_W-1:N]);
    assign imm       = pay_out[N-1:0];
    assign alu_op    = ctrl_q.alu_op;
    assign rd        = ctrl_q.rd;
    assign rs1       = ctrl_q.rs1;
    assign rs2       = ctrl_q.rs2;
    assign src1_pc   = ctrl_q.src1_pc;
    assign src2_imm  = ctrl_q.src2_imm;
    assign rd_we     = ctrl_q.rd_we;
    assign is_branch = ctrl_q.is_branch;
    assign illegal   = ctrl_q.illegal;
    assign br_cond   = ctrl_q.br_cond;

endmodule

// File: tb/tb_rv_alu_decode.sv
// ---------------------------------------------------------------------------
// tb_rv_alu_decode
// Directed self-checking bench for rv_alu_decode: reset state, decode of
// representative RV32I words, skid-buffer backpressure/ordering, and reset
// while the buffer is full. Expected values are hand-computed encodings.
// ---------------------------------------------------------------------------
module tb_rv_alu_decode;

    localparam int N = 32;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_SUB   = 32'h4020_8133; // sub  x2,x1,x2
    localparam logic [31:0] I_SRAI  = 32'h4040_D193; // srai x3,x1,4
    localparam logic [31:0] I_SLTU  = 32'h0020_B233; // sltu x4,x1,x2
    localparam logic [31:0] I_ADDIN = 32'hFFF0_0093; // addi x1,x0,-1
    localparam logic [31:0] I_LUI   = 32'h1234_52B7; // lui  x5,0x12345
    localparam logic [31:0] I_AUIPC = 32'hFFFF_F317; // auipc x6,0xFFFFF
    localparam logic [31:0] I_BADSL = 32'h0200_1093; // slli with funct7 0000001
    localparam logic [31:0] I_ONES  = 32'hFFFF_FFFF;
    localparam logic [31:0] I_BLT   = 32'h0020_C463; // blt x1,x2,+8

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  instr;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   alu_op;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [N-1:0] imm;
    logic         src1_pc;
    logic         src2_imm;
    logic         rd_we;
    logic         is_branch;
    logic         illegal;
    logic [2:0]   br_cond;

    int n_tests;
    int n_fail;

    rv_alu_decode #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .src1_pc   (src1_pc),
        .src2_imm  (src2_imm),
        .rd_we     (rd_we),
        .is_branch (is_branch),
        .illegal   (illegal),
        .br_cond   (br_cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return just after the edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word with out_ready high; on return the decoded bundle
    // should be on the outputs (one cycle after acceptance).
    task automatic send(input logic [31:0] word);
        in_valid  = 1'b1;
        instr     = word;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        instr     = '0;
    endtask

    logic [31:0] words [3];
    logic [4:0]  rds   [3];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = '0;
        out_ready = 1'b1;
        words     = '{I_ADDI, I_SUB, I_SLTU};
        rds       = '{5'd1, 5'd2, 5'd4};

        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_alu_op",    alu_op,    0);
        check("rst_rd",        rd,        0);
        check("rst_imm",       imm,       0);
        check("rst_illegal",   illegal,   0);

        // addi x1,x0,5
        send(I_ADDI);
        check("addi_valid",    out_valid, 1);
        check("addi_alu_op",   alu_op,    4'b0000);
        check("addi_rd",       rd,        1);
        check("addi_rs1",      rs1,       0);
        check("addi_imm",      imm,       5);
        check("addi_src2_imm", src2_imm,  1);
        check("addi_rd_we",    rd_we,     1);
        check("addi_illegal",  illegal,   0);
        tick();
        check("addi_drained",  out_valid, 0);

        // sub x2,x1,x2
        send(I_SUB);
        check("sub_alu_op",   alu_op,   4'b0001);
        check("sub_rd",       rd,       2);
        check("sub_rs1",      rs1,      1);
        check("sub_rs2",      rs2,      2);
        check("sub_src2_imm", src2_imm, 0);
        check("sub_rd_we",    rd_we,    1);

        // srai x3,x1,4
        send(I_SRAI);
        check("srai_alu_op",  alu_op,  4'b0110);
        check("srai_imm",     imm,     4);
        check("srai_rd",      rd,      3);
        check("srai_illegal", illegal, 0);

        // sltu x4,x1,x2
        send(I_SLTU);
        check("sltu_alu_op", alu_op, 4'b1001);
        check("sltu_rd",     rd,     4);

        // addi with negative immediate: sign extension from bit 31
        send(I_ADDIN);
        check("addin_imm", imm, 32'hFFFF_FFFF);

        // lui: rs1 field is nonzero in the encoding but forced to x0
        send(I_LUI);
        check("lui_alu_op",   alu_op,   4'b0000);
        check("lui_rs1",      rs1,      0);
        check("lui_rd",       rd,       5);
        check("lui_imm",      imm,      32'h1234_5000);
        check("lui_src1_pc",  src1_pc,  0);
        check("lui_src2_imm", src2_imm, 1);

        // auipc
        send(I_AUIPC);
        check("auipc_src1_pc",  src1_pc,  1);
        check("auipc_src2_imm", src2_imm, 1);
        check("auipc_imm",      imm,      32'hFFFF_F000);
        check("auipc_rd_we",    rd_we,    1);

        // slli with a non-zero funct7
        send(I_BADSL);
        check("badsl_illegal", illegal, 1);
        check("badsl_rd_we",   rd_we,   0);

        // unrecognised opcode
        send(I_ONES);
        check("ones_illegal",   illegal,   1);
        check("ones_rd_we",     rd_we,     0);
        check("ones_alu_op",    alu_op,    4'b0000);
        check("ones_imm",       imm,       0);
        check("ones_is_branch", is_branch, 0);

        // blt x1,x2,+8
        send(I_BLT);
`ifdef RV_DEC_BRANCH_EN
        check("blt_is_branch", is_branch, 1);
        check("blt_alu_op",    alu_op,    4'b0001);
        check("blt_br_cond",   br_cond,   3'b100);
        check("blt_imm",       imm,       8);
        check("blt_rd_we",     rd_we,     0);
        check("blt_illegal",   illegal,   0);
`else
        check("blt_illegal",   illegal,   1);
        check("blt_is_branch", is_branch, 0);
        check("blt_br_cond",   br_cond,   0);
        check("blt_rd_we",     rd_we,     0);
`endif
        tick();
        check("idle_valid", out_valid, 0);

        // Throughput: back-to-back words with out_ready high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = words[i];
            tick();
            check("tput_valid", out_valid, 1);
            check("tput_rd",    rd,        rds[i]);
        end
        in_valid = 1'b0;
        tick();
        check("tput_drained", out_valid, 0);

        // Backpressure: three back-to-back inputs with out_ready low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = words[0];
        tick();                                   // A accepted
        check("bp_ready_1", in_ready,  1);
        check("bp_valid_1", out_valid, 1);
        check("bp_rd_1",    rd,        1);
        instr = words[1];
        tick();                                   // B accepted -> full
        check("bp_ready_2", in_ready, 0);
        check("bp_hold_2",  rd,       1);
        instr = words[2];
        tick();                                   // C held off
        check("bp_ready_3", in_ready, 0);
        check("bp_hold_3",  rd,       1);
        check("bp_hold_op", alu_op,   4'b0000);
        out_ready = 1'b1;
        tick();                                   // A leaves, B at head
        check("bp_rd_b",    rd,       2);
        check("bp_ready_4", in_ready, 1);
        tick();                                   // B leaves, C accepted
        in_valid = 1'b0;
        check("bp_rd_c",    rd,        4);
        check("bp_valid_c", out_valid, 1);
        tick();                                   // C leaves
        check("bp_empty",   out_valid, 0);

        // Reset while the buffer is full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = words[0];
        tick();
        instr = words[1];
        tick();
        check("rst2_full", in_ready, 0);
        rst   = 1'b1;
        instr = words[2];
        tick();
        check("rst2_valid", out_valid, 0);
        check("rst2_ready", in_ready,  1);
        check("rst2_rd",    rd,        0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rst2_nothing_1", out_valid, 0);
        tick();
        check("rst2_nothing_2", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
